// File: rtl/cpu_program_loader_if.sv
// Byte-stream and instruction-memory write bus between the boot loader and its neighbours.
// The byte source and the memory/CPU side sit on the master modport; the loader uses slave.
interface cpu_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic [7:0]            Rx_Data;
  logic                  Rx_Valid;
  logic                  Rx_Ready;
  logic                  Restart;
  logic                  Mem_WrEn;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [15:0]           Mem_WrData;
  logic [ADDR_WIDTH:0]   Words_Loaded;
  logic                  Cpu_Run;
  logic                  Load_Done;
  logic                  Load_Error;

  modport master (
    output Rx_Data, Rx_Valid, Restart,
    input  Rx_Ready, Mem_WrEn, Mem_Addr, Mem_WrData, Words_Loaded,
           Cpu_Run, Load_Done, Load_Error
  );

  modport slave (
    input  Rx_Data, Rx_Valid, Restart,
    output Rx_Ready, Mem_WrEn, Mem_Addr, Mem_WrData, Words_Loaded,
           Cpu_Run, Load_Done, Load_Error
  );

endinterface

// File: rtl/cpu_program_loader.sv
// Boot loader: takes a framed, XOR-checksummed program image one byte at a time,
// writes it into CPU instruction memory from address 0, then releases the CPU.
module cpu_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input logic                 Clock,
  input logic                 Reset_n,
  cpu_program_loader_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CNT_L  = 3'd1;
  localparam logic [2:0] DATA_H = 3'd2;
  localparam logic [2:0] DATA_L = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [15:0]           count;
  logic [7:0]            high_byte;
  logic [7:0]            checksum;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic [ADDR_WIDTH:0]   words_loaded;
  logic                  rx_ready;
  logic                  mem_wren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wrdata;
  logic                  cpu_run;
  logic                  load_done;
  logic                  load_error;

  logic                  accept;
  logic [15:0]           frame_count;
  logic [16:0]           next_word;
  logic                  last_word;

  // Restart wins over a byte presented in the same cycle.
  always_comb begin
    accept      = bus.Rx_Valid && rx_ready && !bus.Restart;
    frame_count = {count[15:8], bus.Rx_Data};
    next_word   = 17'(words_loaded) + 17'd1;
    last_word   = (next_word == {1'b0, count});
    next_state  = state;
    case (state)
      IDLE:   if (accept) next_state = CNT_L;
      CNT_L:
        if (accept) begin
          if (frame_count == 16'd0 || {1'b0, frame_count} > CAPACITY)
            next_state = ERROR;
          else
            next_state = DATA_H;
        end
      DATA_H: if (accept) next_state = DATA_L;
      DATA_L: if (accept) next_state = last_word ? CHECK : DATA_H;
      CHECK:
        if (accept) next_state = (bus.Rx_Data == checksum) ? DONE : ERROR;
      DONE:   next_state = DONE;
      ERROR:  next_state = ERROR;
      default: next_state = IDLE;
    endcase
    if (bus.Restart) next_state = IDLE;
  end

  // The write pulse is issued the cycle after the low byte is taken, while the
  // FSM is already accepting the next high byte; the pointer advances as it ends.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      count        <= '0;
      high_byte    <= '0;
      checksum     <= '0;
      word_ptr     <= '0;
      words_loaded <= '0;
      rx_ready     <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_wrdata   <= '0;
      cpu_run      <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state    <= next_state;
      rx_ready <= (next_state != DONE) && (next_state != ERROR);
      mem_wren <= 1'b0;
      if (bus.Restart) begin
        count        <= '0;
        high_byte    <= '0;
        checksum     <= '0;
        word_ptr     <= '0;
        words_loaded <= '0;
        mem_addr     <= '0;
        mem_wrdata   <= '0;
        cpu_run      <= 1'b0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
      end else begin
        if (mem_wren) begin
          word_ptr     <= word_ptr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        if (accept) begin
          case (state)
            IDLE: begin
              count[15:8] <= bus.Rx_Data;
              checksum    <= bus.Rx_Data;
            end
            CNT_L: begin
              count    <= frame_count;
              checksum <= checksum ^ bus.Rx_Data;
            end
            DATA_H: begin
              high_byte <= bus.Rx_Data;
              checksum  <= checksum ^ bus.Rx_Data;
            end
            DATA_L: begin
              checksum   <= checksum ^ bus.Rx_Data;
              mem_wren   <= 1'b1;
              mem_addr   <= word_ptr;
              mem_wrdata <= {high_byte, bus.Rx_Data};
            end
            default: ;
          endcase
        end
        load_done  <= (next_state == DONE);
        cpu_run    <= (next_state == DONE);
        load_error <= (next_state == ERROR);
      end
    end
  end

  assign bus.Rx_Ready     = rx_ready;
  assign bus.Mem_WrEn     = mem_wren;
  assign bus.Mem_Addr     = mem_addr;
  assign bus.Mem_WrData   = mem_wrdata;
  assign bus.Words_Loaded = words_loaded;
  assign bus.Cpu_Run      = cpu_run;
  assign bus.Load_Done    = load_done;
  assign bus.Load_Error   = load_error;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for the boot loader; memory writes are predicted into a scoreboard
// queue as frames are sent and matched by a monitor whenever the write strobe fires.
module tb_cpu_program_loader;

  logic Clock;
  logic Reset_n;
  int   passed;
  int   total;
  int   writes;
  int   writes_before;
  logic [23:0] sb[$];

  cpu_program_loader_if #(.ADDR_WIDTH(8)) bus ();

  cpu_program_loader #(.ADDR_WIDTH(8)) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Every strobe must match the oldest predicted write; an unpredicted strobe is an error.
  always @(negedge Clock) begin
    if (Reset_n && bus.Mem_WrEn) begin
      logic [23:0] exp_w;
      writes++;
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("write_addr", 32'(bus.Mem_Addr), 32'(exp_w[23:16]));
        check("write_data", 32'(bus.Mem_WrData), 32'(exp_w[15:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge Clock);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = b;
    while (!bus.Rx_Ready && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    if (!bus.Rx_Ready) check("ready_timeout", 32'(bus.Rx_Ready), 32'd1);
    @(posedge Clock);
    #1;
    bus.Rx_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [15:0] words[$],
                            input logic [7:0] csum_flip, input int gap);
    logic [7:0] csum;
    csum = n[15:8] ^ n[7:0];
    send_byte(n[15:8]); idle(gap);
    send_byte(n[7:0]);  idle(gap);
    for (int i = 0; i < words.size(); i++) begin
      csum = csum ^ words[i][15:8] ^ words[i][7:0];
      sb.push_back({8'(i), words[i]});
      send_byte(words[i][15:8]); idle(gap);
      send_byte(words[i][7:0]);  idle(gap);
    end
    send_byte(csum ^ csum_flip);
    @(negedge Clock);
  endtask

  task automatic do_restart();
    @(negedge Clock);
    bus.Restart = 1'b1;
    @(posedge Clock);
    #1;
    bus.Restart = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 32'(bus.Load_Done), 32'd1);
    check({tag, "_run"}, 32'(bus.Cpu_Run), 32'd1);
    check({tag, "_error"}, 32'(bus.Load_Error), 32'd0);
    check({tag, "_ready"}, 32'(bus.Rx_Ready), 32'd0);
    check({tag, "_words"}, 32'(bus.Words_Loaded), 32'd2);
    check({tag, "_nwrites"}, 32'(writes - writes_before), 32'd2);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] frame1[$];
    frame1 = '{16'h1234, 16'hABCD};
    passed = 0; total = 0; writes = 0;
    Reset_n = 1'b0;
    bus.Restart  = 1'b0;
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data  = 8'h00;

    #3;
    check("rst_ready", 32'(bus.Rx_Ready), 32'd0);
    check("rst_wren", 32'(bus.Mem_WrEn), 32'd0);
    check("rst_addr", 32'(bus.Mem_Addr), 32'd0);
    check("rst_words", 32'(bus.Words_Loaded), 32'd0);
    check("rst_run", 32'(bus.Cpu_Run), 32'd0);
    check("rst_flags", 32'({bus.Load_Done, bus.Load_Error}), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    check("ready_after_reset", 32'(bus.Rx_Ready), 32'd1);

    // Back-to-back good frame
    writes_before = writes;
    send_frame(16'd2, frame1, 8'h00, 0);
    expect_done("t1");
    idle(3);
    check("t1_no_extra_write", 32'(writes - writes_before), 32'd2);

    // Bad checksum
    do_restart();
    check("restart_words", 32'(bus.Words_Loaded), 32'd0);
    check("restart_flags", 32'({bus.Load_Done, bus.Cpu_Run}), 32'd0);
    check("restart_ready", 32'(bus.Rx_Ready), 32'd1);
    writes_before = writes;
    send_frame(16'd2, frame1, 8'h01, 0);
    check("t2_error", 32'(bus.Load_Error), 32'd1);
    check("t2_run", 32'(bus.Cpu_Run), 32'd0);
    check("t2_done", 32'(bus.Load_Done), 32'd0);
    check("t2_nwrites", 32'(writes - writes_before), 32'd2);

    // Zero and oversize counts
    do_restart();
    writes_before = writes;
    send_byte(8'h00); send_byte(8'h00);
    @(negedge Clock);
    check("t3_zero_error", 32'(bus.Load_Error), 32'd1);
    check("t3_zero_ready", 32'(bus.Rx_Ready), 32'd0);
    do_restart();
    send_byte(8'h01); send_byte(8'h01);
    @(negedge Clock);
    check("t3_big_error", 32'(bus.Load_Error), 32'd1);
    idle(3);
    check("t3_nwrites", 32'(writes - writes_before), 32'd0);

    // Stalled frame with gaps between bytes
    do_restart();
    writes_before = writes;
    send_frame(16'd2, frame1, 8'h00, 3);
    expect_done("t4");

    // Restart colliding with a presented byte
    do_restart();
    writes_before = writes;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    @(negedge Clock);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = 8'h34;
    bus.Restart  = 1'b1;
    @(posedge Clock);
    #1;
    bus.Rx_Valid = 1'b0;
    bus.Restart  = 1'b0;
    @(negedge Clock);
    check("t5_words", 32'(bus.Words_Loaded), 32'd0);
    check("t5_ready", 32'(bus.Rx_Ready), 32'd1);
    check("t5_nwrites", 32'(writes - writes_before), 32'd0);
    send_frame(16'd2, frame1, 8'h00, 0);
    expect_done("t5");

    // Asynchronous reset while the second word's low byte is pending
    do_restart();
    writes_before = writes;
    send_byte(8'h00); send_byte(8'h02);
    sb.push_back({8'd0, 16'h1234});
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    @(negedge Clock);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = 8'hCD;
    #2;
    Reset_n = 1'b0;
    #1;
    check("t6_wren", 32'(bus.Mem_WrEn), 32'd0);
    check("t6_words", 32'(bus.Words_Loaded), 32'd0);
    check("t6_ready", 32'(bus.Rx_Ready), 32'd0);
    check("t6_outs", 32'({bus.Mem_Addr, bus.Mem_WrData, bus.Cpu_Run, bus.Load_Done, bus.Load_Error}), 32'd0);
    @(posedge Clock);
    #1;
    bus.Rx_Valid = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    idle(2);
    check("t6_nwrites", 32'(writes - writes_before), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    writes_before = writes;
    send_frame(16'd2, frame1, 8'h00, 1);
    expect_done("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
